// File: rtl/fir_out_axis_bridge.sv
// Purpose: re-times the unthrottled FIR output strobe into an AXI4-Stream master with per-frame tlast.
// Latency: 1 cycle from an accepted s_tvalid to m_tvalid; first-word fall-through, no s_* to m_* comb path.
// Backpressure: m_tready stalls are absorbed by a DEPTH-entry FIFO; samples arriving while it is full are dropped and counted.
module fir_out_axis_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int FRAME_LEN  = 64
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      s_tvalid,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [DATA_WIDTH-1:0]     m_tdata,
  output logic                      m_tlast,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      ovf,
  input  logic                      ovf_clr,
  output logic [15:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [BW-1:0]         beat;

  logic pop;
  logic full;
  logic push;
  logic drop;
  logic beat_last;

  // Handshake qualifiers; a pop frees a slot so a full FIFO can still accept in the same cycle.
  always_comb begin
    m_tvalid  = (level != '0);
    m_tdata   = mem[rd_ptr];
    beat_last = (beat == BW'(FRAME_LEN - 1));
    m_tlast   = m_tvalid && beat_last;
    pop       = m_tvalid && m_tready;
    full      = (level == LW'(DEPTH));
    push      = s_tvalid && (!full || pop);
    drop      = s_tvalid && full && !pop;
  end

  // Sample storage; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (nrst && push) begin
      mem[wr_ptr] <= s_tdata;
    end
  end

  // Pointers, occupancy and frame position; power-of-two depth makes pointer wrap free.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      beat   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        beat   <= beat_last ? '0 : beat + BW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Overflow bookkeeping; a drop in the same cycle as a clear wins and restarts the count at 1.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (ovf_clr) begin
        drop_cnt <= 16'd1;
      end else if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end else if (ovf_clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_fir_out_axis_bridge.sv
// Bench for fir_out_axis_bridge: fixed vector table, directed corner sequences and a randomized run,
// all cross-checked every cycle against a queue-based reference of the FIFO/frame/overflow behaviour.
module tb_fir_out_axis_bridge;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int FLEN  = 4;

  logic            clk = 1'b0;
  logic            nrst;
  logic            s_tvalid;
  logic [DW-1:0]   s_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tlast;
  logic [$clog2(DEPTH):0] level;
  logic            ovf;
  logic            ovf_clr;
  logic [15:0]     drop_cnt;

  fir_out_axis_bridge #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FRAME_LEN(FLEN)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .level    (level),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: the FIFO as a queue, frame position as delivered-beat count mod FLEN.
  logic [DW-1:0] mq[$];
  int            m_delivered;
  logic          m_ovf;
  int            m_drop;

  // Observed handshake in the cycle just stepped.
  logic          pop_evt;
  logic          pop_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic e_vld;
    e_vld = (mq.size() != 0);
    check("m_tvalid", m_tvalid, e_vld);
    check("m_tlast", m_tlast, e_vld && ((m_delivered % FLEN) == FLEN - 1));
    check("level", level, mq.size());
    check("ovf", ovf, m_ovf);
    check("drop_cnt", drop_cnt, m_drop);
    if (e_vld) check("m_tdata", m_tdata, mq[0]);
  endtask

  // Drive one cycle of inputs, advance the reference, and compare after the edge.
  task automatic step(input logic n, input logic sv, input logic [31:0] sd,
                      input logic rdy, input logic clr);
    logic mpop;
    logic mfull;
    logic mdrop;
    nrst = n; s_tvalid = sv; s_tdata = sd; m_tready = rdy; ovf_clr = clr;
    pop_evt  = m_tvalid && rdy && n;
    pop_last = m_tlast;
    if (!n) begin
      mq.delete();
      m_delivered = 0;
      m_ovf = 1'b0;
      m_drop = 0;
    end else begin
      mpop  = (mq.size() != 0) && rdy;
      mfull = (mq.size() == DEPTH);
      mdrop = sv && mfull && !mpop;
      if (mpop) begin
        void'(mq.pop_front());
        m_delivered++;
      end
      if (sv && !mdrop) mq.push_back(sd);
      if (mdrop) begin
        m_ovf  = 1'b1;
        m_drop = clr ? 1 : ((m_drop == 65535) ? 65535 : m_drop + 1);
      end else if (clr) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    logic        n, sv;
    logic [31:0] sd;
    logic        rdy, clr;
    logic        e_vld, e_last;
    logic [31:0] e_dat;
    int          e_lvl;
    logic        e_ovf;
    int          e_drop;
  } vec_t;

  vec_t tbl[8];
  int   idx;
  int   guard;

  initial begin
    nrst = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0; ovf_clr = 1'b0;
    m_delivered = 0; m_ovf = 1'b0; m_drop = 0;
    pop_evt = 1'b0; pop_last = 1'b0;

    //          n  sv  sd            rdy clr  vld last dat           lvl ovf drop
    tbl[0] = '{1'b0,1'b0,32'h0,        1'b0,1'b0, 1'b0,1'b0,32'h0,        0, 1'b0,0};
    tbl[1] = '{1'b1,1'b1,32'h00007FFF, 1'b1,1'b0, 1'b1,1'b0,32'h00007FFF, 1, 1'b0,0};
    tbl[2] = '{1'b1,1'b0,32'h0,        1'b1,1'b0, 1'b0,1'b0,32'h0,        0, 1'b0,0};
    tbl[3] = '{1'b1,1'b1,32'hAAAA0001, 1'b0,1'b0, 1'b1,1'b0,32'hAAAA0001, 1, 1'b0,0};
    tbl[4] = '{1'b1,1'b1,32'hBBBB0002, 1'b0,1'b0, 1'b1,1'b0,32'hAAAA0001, 2, 1'b0,0};
    tbl[5] = '{1'b1,1'b0,32'h0,        1'b1,1'b0, 1'b1,1'b0,32'hBBBB0002, 1, 1'b0,0};
    tbl[6] = '{1'b1,1'b1,32'h8000CCCC, 1'b1,1'b0, 1'b1,1'b1,32'h8000CCCC, 1, 1'b0,0};
    tbl[7] = '{1'b1,1'b0,32'h0,        1'b1,1'b0, 1'b0,1'b0,32'h0,        0, 1'b0,0};

    @(negedge clk);

    // Impulse passthrough and a short stall/frame sequence from the table.
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].n, tbl[i].sv, tbl[i].sd, tbl[i].rdy, tbl[i].clr);
      check($sformatf("tbl%0d_vld", i), m_tvalid, tbl[i].e_vld);
      check($sformatf("tbl%0d_last", i), m_tlast, tbl[i].e_last);
      check($sformatf("tbl%0d_lvl", i), level, tbl[i].e_lvl);
      check($sformatf("tbl%0d_ovf", i), ovf, tbl[i].e_ovf);
      check($sformatf("tbl%0d_drop", i), drop_cnt, tbl[i].e_drop);
      if (tbl[i].e_vld) check($sformatf("tbl%0d_dat", i), m_tdata, tbl[i].e_dat);
    end

    // Stall and fill, then one overflowing push, then release in order.
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, i, 1'b0, 1'b0);
      check("fill_head", m_tdata, 1);
    end
    check("fill_level", level, 16);
    check("fill_ovf", ovf, 0);
    step(1'b1, 1'b1, 32'd17, 1'b0, 1'b0);
    check("drop_ovf", ovf, 1);
    check("drop_cnt1", drop_cnt, 1);
    check("drop_level", level, 16);
    for (int i = 1; i <= 16; i++) begin
      check("drain_vld", m_tvalid, 1);
      check("drain_dat", m_tdata, i);
      step(1'b1, 1'b0, 0, 1'b1, 1'b0);
    end
    check("drain_empty", m_tvalid, 0);

    // Full with simultaneous push and pop across pointer wrap.
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 100 + i, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 200 + i, 1'b1, 1'b0);
      check("pp_level", level, 16);
      check("pp_nodrop", drop_cnt, 0);
    end
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 0, 1'b1, 1'b0);

    // Framing with random ready gaps: tlast only on delivered beats 3 and 7.
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 32'h1000 + i, $urandom_range(0, 2) != 0, 1'b0);
      if (pop_evt) begin
        check($sformatf("frame_last_b%0d", idx), pop_last, (idx == 3) || (idx == 7));
        idx++;
      end
    end
    guard = 0;
    while (m_tvalid && guard < 300) begin
      step(1'b1, 1'b0, 0, $urandom_range(0, 2) != 0, 1'b0);
      if (pop_evt) begin
        check($sformatf("frame_last_b%0d", idx), pop_last, (idx == 3) || (idx == 7));
        idx++;
      end
      guard++;
    end
    check("frame_delivered", idx, 10);

    // Overflow clear coincident with a drop, clear alone, then saturation.
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, i, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b1);
    check("clr_drop_ovf", ovf, 1);
    check("clr_drop_cnt", drop_cnt, 1);
    step(1'b1, 1'b0, 0, 1'b0, 1'b1);
    check("clr_ovf", ovf, 0);
    check("clr_cnt", drop_cnt, 0);
    for (int i = 0; i < 70000; i++) step(1'b1, 1'b1, i, 1'b0, 1'b0);
    check("sat_cnt", drop_cnt, 16'hFFFF);
    check("sat_ovf", ovf, 1);
    check("sat_level", level, 16);

    // Reset mid-frame with level 9 and beat 2.
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2, 1'b1, 1'b0);
    step(1'b1, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 50 + i, 1'b0, 1'b0);
    check("pre_rst_level", level, 9);
    step(1'b0, 1'b1, 32'hBAD, 1'b1, 1'b0);
    check("rst_vld", m_tvalid, 0);
    check("rst_level", level, 0);
    check("rst_last", m_tlast, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 300 + i, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("post_rst_last%0d", i), m_tlast, i == 3);
      check($sformatf("post_rst_dat%0d", i), m_tdata, 300 + i);
      step(1'b1, 1'b0, 0, 1'b1, 1'b0);
    end

    // Randomized traffic against the reference model.
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 3) != 0,
           $urandom,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_out_axis_bridge.md
# fir_out_axis_bridge

Output-side companion to the `fir` decimator. It captures the FIR's unthrottled output strobe (`m_tvalid`/`m_tdata`, which has no ready) and re-emits the samples as an AXI4-Stream master with full backpressure and per-frame `m_tlast`. A small circular FIFO absorbs downstream stalls. Samples arriving while the FIFO is full are dropped; drops are counted and flagged. The block sits between the FIR output and the DMA/packetizer.

## Interface
Parameters:
- `DATA_WIDTH`, 32: sample width; matches the FIR `m_tdata`.
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥ 2.
- `FRAME_LEN`, 64: output beats per frame; `m_tlast` marks the last beat; must be ≥ 1.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `nrst`  in  1: reset, synchronous, active-low.
- `s_tvalid`  in  1: sample strobe from the FIR `m_tvalid`; cannot be stalled.
- `s_tdata`  in  DATA_WIDTH: sample from the FIR `m_tdata`; signed, passed unmodified.
- `m_tvalid`  out  1: AXIS valid.
- `m_tready`  in  1: AXIS ready.
- `m_tdata`  out  DATA_WIDTH: AXIS data.
- `m_tlast`  out  1: high on beat `FRAME_LEN-1` of each frame.
- `level`  out  $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `ovf`  out  1: sticky flag; a sample was dropped.
- `ovf_clr`  in  1: clears `ovf` and `drop_cnt`.
- `drop_cnt`  out  16: saturating count of dropped samples.

## Operation
- Storage: `DEPTH` × `DATA_WIDTH` array with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits.
  - Pointers wrap modulo `DEPTH`.
  - Occupancy is tracked by `level`, not derived from the pointers.
- Definitions:
  - `pop = m_tvalid && m_tready`.
  - `full = (level == DEPTH)`.
  - `push = s_tvalid && (!full || pop)`.
- Output drive:
  - `m_tvalid = (level != 0)`.
  - `m_tdata = mem[rd_ptr]`, first-word fall-through.
- Push: write `mem[wr_ptr]` and increment `wr_ptr`.
- Pop: increment `rd_ptr`.
- `level` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when both occur or neither occurs.
- Drop occurs when `s_tvalid && full && !pop`:
  - The sample is discarded and the pointers do not move.
  - `ovf` is set to 1.
  - `drop_cnt` increments, saturating at 0xFFFF.
- `ovf_clr`:
  - Clears `ovf` and `drop_cnt` to 0 on the next edge.
  - If a drop occurs in the same cycle, set wins: `ovf` = 1 and `drop_cnt` = 1.
- Frame counter `beat`, range 0..FRAME_LEN-1:
  - Advances only on pop; wraps to 0 after `FRAME_LEN-1`.
  - `m_tlast = m_tvalid && (beat == FRAME_LEN-1)`.
  - Drops do not affect `beat`; frames count delivered beats only.
- Arithmetic: none. Data is stored and forwarded bit-exact; no sign extension or rescaling.

## Timing
- Reset (`nrst` low at an edge) forces the following on that edge:
  - `wr_ptr`, `rd_ptr`, `level`, `beat`, `ovf`, `drop_cnt` = 0.
  - Outputs: `m_tvalid` = 0, `m_tlast` = 0, `level` = 0, `ovf` = 0, `drop_cnt` = 0.
  - `m_tdata` is don't-care, but the array is not reset.
- Reset mid-frame or mid-stall:
  - All contents are discarded and `beat` restarts at 0.
  - `s_tvalid` is ignored while `nrst` = 0.
- Latency: a sample pushed at edge k into an empty FIFO gives `m_tvalid` = 1 with that data in the cycle after edge k.
  - Minimum latency is 1 cycle.
  - There is no combinational path from `s_*` to `m_*`.
- AXIS rules:
  - While `m_tvalid && !m_tready`, `m_tdata` and `m_tlast` hold stable; a push to a different slot does not disturb the head.
  - `m_tvalid` never drops without a pop.
- Throughput: one push and one pop per cycle sustained.
- Boundary cases:
  - Empty with `s_tvalid`: push only; no pop is possible that cycle.
  - Full with `s_tvalid` and pop in the same cycle: accepted; `level` stays at DEPTH; no drop.
  - Full with `s_tvalid` and no pop: drop.
  - Pointer wrap from DEPTH-1 to 0 is seamless.

## Test plan
- **Impulse passthrough**
  - Stimulus: after reset, one `s_tvalid` pulse with 0x00007FFF; `m_tready` = 1.
  - Required: one cycle later `m_tvalid` = 1 with `m_tdata` = 0x00007FFF; then `m_tvalid` = 0, `level` = 0.
- **Stall and fill**
  - Stimulus: `m_tready` = 0; push 16 samples 1..16.
  - Required: `level` = 16; `m_tdata` = 1 stable throughout; `ovf` = 0.
  - Stimulus: one further push.
  - Required: `ovf` = 1, `drop_cnt` = 1, `level` stays 16.
  - Stimulus: release `m_tready`.
  - Required: outputs 1..16 in order, no gaps.
- **Full with simultaneous push and pop**
  - Stimulus: FIFO full; `m_tready` = 1 and `s_tvalid` = 1 for 20 cycles.
  - Required: `level` = 16 every cycle; no drops; output order preserved across pointer wrap.
- **Framing**
  - Stimulus: `FRAME_LEN` = 4; stream 10 samples with random `m_tready` gaps.
  - Required: `m_tlast` on delivered beats 3 and 7 only; a stall on a last beat holds `m_tlast` high until accepted.
- **Overflow clear**
  - Stimulus: `ovf_clr` in the same cycle as a drop.
  - Required: `ovf` = 1, `drop_cnt` = 1.
  - Stimulus: `ovf_clr` alone.
  - Required: `ovf` = 0, `drop_cnt` = 0.
  - Stimulus: 70000 forced drops.
  - Required: `drop_cnt` = 0xFFFF.
- **Reset mid-operation**
  - Stimulus: `level` = 9 and `beat` = 2; assert `nrst` = 0 for one edge.
  - Required: `m_tvalid` = 0, `level` = 0.
  - Stimulus: 4 new samples.
  - Required: `m_tlast` on the 4th sample (`FRAME_LEN` = 4).
